// File: rtl/text_render_pipe.sv
// Pixel-domain text renderer: VRAM glyph fetch, font lookup, palette and cursor.
// Three-stage pipeline aligned with delayed hsync/vsync/vde.
module text_render_pipe #(
  parameter int H_CHARS      = 80,
  parameter int V_CHARS      = 30,
  parameter int VRAM_DW      = 32,
  parameter int VRAM_AW      = 11,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               pixel_clk,
  input  logic               arstn,
  input  logic [9:0]         drawX,
  input  logic [9:0]         drawY,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic               vde_in,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [VRAM_DW-1:0] vram_rdata,
  output logic [10:0]        font_addr,
  input  logic [7:0]         font_data,
  input  logic [191:0]       palette,
  input  logic               cursor_en,
  input  logic               cursor_blink,
  input  logic [6:0]         cursor_col,
  input  logic [4:0]         cursor_row,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               hs_out,
  output logic               vs_out,
  output logic               vde_out
);

  localparam int GPW = VRAM_DW / 16;
  localparam int GSH = $clog2(GPW);
  localparam logic [9:0] HC = 10'(H_CHARS);
  localparam logic [9:0] VC = 10'(V_CHARS);
  localparam logic [7:0] BL = 8'(BLINK_FRAMES - 1);

  logic [6:0]  col;
  logic [5:0]  row;
  logic [19:0] idx;
  logic        oob0;
  logic        hit0;
  logic        blink_vis;

  logic [7:0]  frame_cnt;
  logic        blink_phase;
  logic        vs_prev;
  logic        vs_fall;

  logic [GSH-1:0] s1_slot;
  logic [2:0]     s1_xbit;
  logic [3:0]     s1_yrow;
  logic           s1_oob;
  logic           s1_hit;
  logic [15:0]    glyph;

  logic       s2_inv;
  logic [3:0] s2_fg;
  logic [3:0] s2_bg;
  logic [2:0] s2_xbit;
  logic       s2_oob;
  logic       s2_hit;
  logic       pix;
  logic [3:0] sel;
  logic [7:0] base;
  logic [11:0] color;

  logic [2:0] hs_d;
  logic [2:0] vs_d;
  logic [2:0] vde_d;

  assign col  = drawX[9:3];
  assign row  = drawY[9:4];
  assign idx  = 20'(row) * 20'(H_CHARS) + 20'(col);
  assign oob0 = ({3'b0, col} >= HC) || ({4'b0, row} >= VC);

  assign blink_vis = blink_phase || !cursor_blink;
  assign hit0 = cursor_en && !oob0 && blink_vis
             && col == cursor_col && row == {1'b0, cursor_row};

  assign vs_fall = vs_prev && !vs_in;

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
      vs_prev     <= 1'b1;
    end else begin
      vs_prev <= vs_in;
      if (vs_fall) begin
        if (frame_cnt == BL) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      vram_addr <= '0;
      s1_slot   <= '0;
      s1_xbit   <= '0;
      s1_yrow   <= '0;
      s1_oob    <= 1'b0;
      s1_hit    <= 1'b0;
    end else begin
      vram_addr <= VRAM_AW'(idx >> GSH);
      s1_slot   <= idx[GSH-1:0];
      s1_xbit   <= drawX[2:0];
      s1_yrow   <= drawY[3:0];
      s1_oob    <= oob0;
      s1_hit    <= hit0;
    end
  end

  assign glyph = vram_rdata[{s1_slot, 4'h0} +: 16];

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      font_addr <= '0;
      s2_inv    <= 1'b0;
      s2_fg     <= '0;
      s2_bg     <= '0;
      s2_xbit   <= '0;
      s2_oob    <= 1'b0;
      s2_hit    <= 1'b0;
    end else begin
      font_addr <= {glyph[14:8], s1_yrow};
      s2_inv    <= glyph[15];
      s2_fg     <= glyph[7:4];
      s2_bg     <= glyph[3:0];
      s2_xbit   <= s1_xbit;
      s2_oob    <= s1_oob;
      s2_hit    <= s1_hit;
    end
  end

  // vde_d[1] is the vde belonging to the pixel now in stage 2
  assign pix   = font_data[3'd7 - s2_xbit] ^ s2_inv ^ s2_hit;
  assign sel   = pix ? s2_fg : s2_bg;
  assign base  = 8'(sel) * 8'd12;
  assign color = palette[base +: 12];

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
      vde_d <= '0;
    end else begin
      if (s2_oob || !vde_d[1]) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        red   <= color[11:8];
        green <= color[7:4];
        blue  <= color[3:0];
      end
      hs_d  <= {hs_d[1:0], hs_in};
      vs_d  <= {vs_d[1:0], vs_in};
      vde_d <= {vde_d[1:0], vde_in};
    end
  end

  assign hs_out  = hs_d[2];
  assign vs_out  = vs_d[2];
  assign vde_out = vde_d[2];

endmodule

// File: tb/tb_text_render_pipe.sv
// Bench for text_render_pipe: 32-bit and 64-bit VRAM variants rendering
// the same screen, checked against a cell/font/palette picture model.
module tb_text_render_pipe;

  localparam int H  = 80;
  localparam int V  = 30;
  localparam int BF = 2;

  logic        pixel_clk = 1'b0;
  logic        arstn = 1'b0;
  logic [9:0]  draw_x = '0;
  logic [9:0]  draw_y = '0;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        vde = 1'b0;
  logic [191:0] palette = '0;
  logic        cur_en = 1'b0;
  logic        cur_blink = 1'b0;
  logic [6:0]  cur_col = '0;
  logic [4:0]  cur_row = '0;

  logic [10:0] va32;
  logic [9:0]  va64;
  logic [31:0] vd32;
  logic [63:0] vd64;
  logic [10:0] fa32, fa64;
  logic [7:0]  fd32, fd64;
  logic [3:0]  r32, g32, b32, r64, g64, b64;
  logic        hso32, vso32, vdeo32, hso64, vso64, vdeo64;

  logic [15:0] glyphs [4096];
  logic [7:0]  font [2048];

  int total = 0;
  int bad = 0;
  int falls = 0;
  logic prev_vs = 1'b1;
  logic [14:0] expq [$];

  always #5 pixel_clk = ~pixel_clk;

  assign vd32 = {glyphs[{va32, 1'b1}], glyphs[{va32, 1'b0}]};
  assign vd64 = {glyphs[{va64, 2'd3}], glyphs[{va64, 2'd2}],
                 glyphs[{va64, 2'd1}], glyphs[{va64, 2'd0}]};
  assign fd32 = font[fa32];
  assign fd64 = font[fa64];

  text_render_pipe #(.H_CHARS(H), .V_CHARS(V), .VRAM_DW(32),
    .VRAM_AW(11), .BLINK_FRAMES(BF)) u32 (
    .pixel_clk(pixel_clk), .arstn(arstn), .drawX(draw_x), .drawY(draw_y),
    .hs_in(hs), .vs_in(vs), .vde_in(vde),
    .vram_addr(va32), .vram_rdata(vd32),
    .font_addr(fa32), .font_data(fd32), .palette(palette),
    .cursor_en(cur_en), .cursor_blink(cur_blink),
    .cursor_col(cur_col), .cursor_row(cur_row),
    .red(r32), .green(g32), .blue(b32),
    .hs_out(hso32), .vs_out(vso32), .vde_out(vdeo32));

  text_render_pipe #(.H_CHARS(H), .V_CHARS(V), .VRAM_DW(64),
    .VRAM_AW(10), .BLINK_FRAMES(BF)) u64 (
    .pixel_clk(pixel_clk), .arstn(arstn), .drawX(draw_x), .drawY(draw_y),
    .hs_in(hs), .vs_in(vs), .vde_in(vde),
    .vram_addr(va64), .vram_rdata(vd64),
    .font_addr(fa64), .font_data(fd64), .palette(palette),
    .cursor_en(cur_en), .cursor_blink(cur_blink),
    .cursor_col(cur_col), .cursor_row(cur_row),
    .red(r64), .green(g64), .blue(b64),
    .hs_out(hso64), .vs_out(vso64), .vde_out(vdeo64));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected {rgb, hs, vs, vde} for the pixel currently on the inputs
  function automatic logic [14:0] model();
    int col, row, idx, k;
    logic [15:0] g;
    logic [7:0] f;
    logic fb, vis, cur, p;
    logic [11:0] rgb;
    rgb = '0;
    col = int'(draw_x) / 8;
    row = int'(draw_y) / 16;
    if (vde && col < H && row < V) begin
      idx = row * H + col;
      g   = glyphs[idx];
      f   = font[{g[14:8], draw_y[3:0]}];
      fb  = f[7 - (int'(draw_x) % 8)];
      vis = ((falls / BF) % 2 == 0) || !cur_blink;
      cur = cur_en && vis && col == int'(cur_col) && row == int'(cur_row);
      p   = fb ^ g[15] ^ cur;
      k   = p ? int'(g[7:4]) : int'(g[3:0]);
      rgb = palette[12*k +: 12];
    end
    return {rgb, hs, vs, vde};
  endfunction

  task automatic step();
    logic [14:0] e;
    expq.push_back(model());
    if (prev_vs && !vs) falls++;
    prev_vs = vs;
    @(posedge pixel_clk);
    #1;
    if (expq.size() == 3) begin
      e = expq.pop_front();
      check("pix32", {r32, g32, b32, hso32, vso32, vdeo32}, e);
      check("pix64", {r64, g64, b64, hso64, vso64, vdeo64}, e);
    end
  endtask

  task automatic flush();
    vde = 1'b0;
    repeat (3) step();
    vde = 1'b1;
  endtask

  task automatic do_reset(int n);
    arstn = 1'b0;
    repeat (n) @(posedge pixel_clk);
    #1;
    check("rst_rgb", {r32, g32, b32, r64, g64, b64}, 0);
    check("rst_sync", {hso32, vso32, vdeo32, hso64, vso64, vdeo64}, 0);
    check("rst_addr32", {va32, fa32}, 0);
    check("rst_addr64", {va64, fa64}, 0);
    arstn = 1'b1;
    expq.delete();
    expq.push_back('0);
    expq.push_back('0);
    falls = 0;
    prev_vs = 1'b1;
  endtask

  task automatic px(int x, int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    step();
    step();
    step();
  endtask

  task automatic rand_run(int n);
    for (int i = 0; i < n; i++) begin
      draw_x = 10'($urandom_range(0, 700));
      draw_y = 10'($urandom_range(0, 520));
      if ($urandom_range(0, 7) == 0) draw_x = 10'(639 + $urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) draw_y = 10'(479 + $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        cur_col = 7'(draw_x >> 3);
        cur_row = 5'(draw_y >> 4);
      end else begin
        cur_col = 7'($urandom_range(0, 127));
        cur_row = 5'($urandom_range(0, 31));
      end
      cur_en    = ($urandom_range(0, 3) != 0);
      cur_blink = 1'($urandom_range(0, 1));
      vde       = ($urandom_range(0, 7) != 0);
      hs        = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) glyphs[i] = 16'($urandom());
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom());
    for (int i = 0; i < 6; i++) palette[32*i +: 32] = $urandom();
    palette[12*1 +: 12] = 12'h00F;
    palette[12*2 +: 12] = 12'hF00;
    glyphs[162] = 16'h4A21;
    font[{7'h4A, 4'd3}] = 8'h40;
    glyphs[7] = 16'h4A21;
    font[{7'h4A, 4'd0}] = 8'hFF;

    do_reset(3);
    vde = 1'b1;

    draw_x = 10'd17;
    draw_y = 10'd35;
    step();
    check("vaddr32", 32'(va32), 81);
    check("vaddr64", 32'(va64), 40);
    step();
    check("faddr32", 32'(fa32), {7'h4A, 4'd3});
    step();
    check("rgb_fg", {r32, g32, b32}, 12'hF00);

    flush();
    glyphs[162] = 16'hCA21;
    px(17, 35);
    check("rgb_inv", {r32, g32, b32}, 12'h00F);
    flush();
    glyphs[162] = 16'h4A21;

    draw_x = 10'd56;
    draw_y = 10'd0;
    step();
    check("vaddr64_idx7", 32'(va64), 1);
    check("vaddr32_idx7", 32'(va32), 3);
    step();
    step();
    check("rgb64_slot3", {r64, g64, b64}, 12'hF00);

    px(640, 35);
    check("oob_x", {r32, g32, b32}, 0);
    px(17, 480);
    check("oob_y", {r64, g64, b64}, 0);
    vde = 1'b0;
    px(17, 35);
    check("blank", {r32, g32, b32}, 0);
    vde = 1'b1;
    px(639, 479);
    px(632, 464);

    cur_en = 1'b1;
    cur_blink = 1'b1;
    cur_col = 7'd2;
    cur_row = 5'd2;
    for (int f = 0; f < 4; f++) begin
      px(17, 35);
      check("blink", {r32, g32, b32}, (f < 2) ? 12'h00F : 12'hF00);
      vs = 1'b0;
      step();
      vs = 1'b1;
      step();
    end
    cur_blink = 1'b0;
    for (int f = 0; f < 2; f++) begin
      px(17, 35);
      check("solid", {r64, g64, b64}, 12'h00F);
      vs = 1'b0;
      step();
      vs = 1'b1;
      step();
    end
    cur_col = 7'd100;
    px(17, 35);
    check("cur_out_grid", {r32, g32, b32}, 12'hF00);

    rand_run(1500);

    do_reset(2);
    hs = 1'b1;
    vs = 1'b1;
    vde = 1'b1;
    cur_en = 1'b1;
    cur_blink = 1'b1;
    cur_col = 7'd2;
    cur_row = 5'd2;
    px(17, 35);
    check("post_rst_cursor", {r32, g32, b32, r64, g64, b64}, {12'h00F, 12'h00F});

    rand_run(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
